// File: rtl/owl_pkg.sv
// Shared types and command-entry layout for the one-wire-link command sequencer.
package owl_pkg;

    localparam int OWL_ADDR_W  = 7;
    localparam int OWL_BYTE_W  = 8;
    localparam int OWL_ENTRY_W = 40;

    // Entry layout, MSB first: op | addr | num | d0 | d1 | d2
    localparam int OWL_D2_LSB   = 0;
    localparam int OWL_D1_LSB   = 8;
    localparam int OWL_D0_LSB   = 16;
    localparam int OWL_NUM_LSB  = 24;
    localparam int OWL_ADDR_LSB = 32;
    localparam int OWL_OP_BIT   = 39;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_GAP
    } seq_state_e;

    function automatic logic [OWL_ENTRY_W-1:0] owl_pack_entry(
        input logic                  op,
        input logic [OWL_ADDR_W-1:0] addr,
        input logic [OWL_BYTE_W-1:0] num,
        input logic [OWL_BYTE_W-1:0] d0,
        input logic [OWL_BYTE_W-1:0] d1,
        input logic [OWL_BYTE_W-1:0] d2
    );
        return {op, addr, num, d0, d1, d2};
    endfunction

endpackage

// File: rtl/owl_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO with level/full/empty and a one-cycle flush.
module owl_cmd_fifo
    import owl_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [OWL_ENTRY_W-1:0]       wdata,
    output logic [OWL_ENTRY_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [OWL_ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_q, rd_q;
    logic [AW:0]            cnt_q;
    logic                   do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign level   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/owl_cmd_seq.sv
// Command sequencer: queues write commands and launches them on the owl_mctrl SFR port
// as single-cycle strobes separated by a programmable guard gap.
module owl_cmd_seq
    import owl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int GAP_WIDTH = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_push,
    input  logic                  cmd_op,
    input  logic [OWL_ADDR_W-1:0] cmd_addr,
    input  logic [OWL_BYTE_W-1:0] cmd_num,
    input  logic [OWL_BYTE_W-1:0] cmd_d0,
    input  logic [OWL_BYTE_W-1:0] cmd_d1,
    input  logic [OWL_BYTE_W-1:0] cmd_d2,
    input  logic                  seq_en,
    input  logic                  flush,
    input  logic [GAP_WIDTH-1:0]  gap_cfg,
    input  logic                  mst_busy,
    input  logic                  ovf_clr,
    output logic                  sfr_cmd,
    output logic [OWL_ADDR_W-1:0] sfr_addrs,
    output logic [OWL_BYTE_W-1:0] sfr_num,
    output logic [OWL_BYTE_W-1:0] sfr_wdata,
    output logic [OWL_BYTE_W-1:0] sfr_wdata1,
    output logic [OWL_BYTE_W-1:0] sfr_wdata2,
    output logic                  sfr_wctrl,
    output logic                  cmd_full,
    output logic [$clog2(DEPTH):0] cmd_level,
    output logic                  seq_busy,
    output logic                  ovf
);

    seq_state_e              state_q, state_d;
    logic [GAP_WIDTH-1:0]    cnt_q, cnt_d;
    logic [OWL_ENTRY_W-1:0]  ent_q, fifo_rdata;
    logic                    ovf_q, ovf_set;
    logic                    pop, fifo_empty;

    owl_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .pop   (pop),
        .flush (flush),
        .wdata (owl_pack_entry(cmd_op, cmd_addr, cmd_num, cmd_d0, cmd_d1, cmd_d2)),
        .rdata (fifo_rdata),
        .level (cmd_level),
        .full  (cmd_full),
        .empty (fifo_empty)
    );

    assign ovf_set = cmd_push & cmd_full & ~pop & ~flush;

    // A zero gap skips GAP entirely so strobes land gap_cfg+2 cycles apart.
    // A flush racing into LOAD can leave nothing to pop; fall back to IDLE without a strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seq_en && !fifo_empty && !mst_busy) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_d = gap_cfg;
                if (gap_cfg == '0 && !mst_busy)
                    state_d = (seq_en && !fifo_empty) ? ST_LOAD : ST_IDLE;
                else
                    state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - GAP_WIDTH'(1);
                if (cnt_q <= GAP_WIDTH'(1) && !mst_busy)
                    state_d = (seq_en && !fifo_empty) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ent_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) ent_q <= fifo_rdata;
            ovf_q   <= (ovf_q & ~ovf_clr) | ovf_set;
        end
    end

    assign sfr_cmd    = ent_q[OWL_OP_BIT];
    assign sfr_addrs  = ent_q[OWL_ADDR_LSB +: OWL_ADDR_W];
    assign sfr_num    = ent_q[OWL_NUM_LSB  +: OWL_BYTE_W];
    assign sfr_wdata  = ent_q[OWL_D0_LSB   +: OWL_BYTE_W];
    assign sfr_wdata1 = ent_q[OWL_D1_LSB   +: OWL_BYTE_W];
    assign sfr_wdata2 = ent_q[OWL_D2_LSB   +: OWL_BYTE_W];
    assign sfr_wctrl  = (state_q == ST_START);
    assign seq_busy   = (state_q != ST_IDLE);
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_owl_cmd_seq.sv
// Directed bench for owl_cmd_seq: per-cycle vector table plus multi-cycle sequences.
module tb_owl_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_push, cmd_op, seq_en, flush, mst_busy, ovf_clr;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_num, cmd_d0, cmd_d1, cmd_d2;
    logic [15:0] gap_cfg;
    logic        sfr_cmd, sfr_wctrl, cmd_full, seq_busy, ovf;
    logic [6:0]  sfr_addrs;
    logic [7:0]  sfr_num, sfr_wdata, sfr_wdata1, sfr_wdata2;
    logic [2:0]  cmd_level;
    logic [39:0] oent;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [39:0] stb_ent[$];
    int          stb_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    owl_cmd_seq #(.DEPTH(4), .GAP_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cmd_push(cmd_push), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_num(cmd_num), .cmd_d0(cmd_d0), .cmd_d1(cmd_d1), .cmd_d2(cmd_d2),
        .seq_en(seq_en), .flush(flush), .gap_cfg(gap_cfg), .mst_busy(mst_busy),
        .ovf_clr(ovf_clr), .sfr_cmd(sfr_cmd), .sfr_addrs(sfr_addrs), .sfr_num(sfr_num),
        .sfr_wdata(sfr_wdata), .sfr_wdata1(sfr_wdata1), .sfr_wdata2(sfr_wdata2),
        .sfr_wctrl(sfr_wctrl), .cmd_full(cmd_full), .cmd_level(cmd_level),
        .seq_busy(seq_busy), .ovf(ovf)
    );

    assign oent = {sfr_cmd, sfr_addrs, sfr_num, sfr_wdata, sfr_wdata1, sfr_wdata2};

    always @(negedge clk) begin
        if (sfr_wctrl === 1'b1) begin
            stb_ent.push_back(oent);
            stb_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic        push;
        logic [39:0] ent;
        logic        en;
        logic        clr;
        logic [2:0]  xlvl;
        logic        xfull;
        logic        xovf;
        logic        xbusy;
        logic        xstb;
        logic [39:0] xent;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [39:0] mk(input logic op, input logic [6:0] a, input logic [7:0] n,
                                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        return {op, a, n, d0, d1, d2};
    endfunction

    function automatic vec_t mkv(input logic p, input logic [39:0] e, input logic en, input logic clr,
                                 input logic [2:0] l, input logic f, input logic o, input logic b,
                                 input logic s, input logic [39:0] x);
        vec_t v;
        v.push = p; v.ent = e; v.en = en; v.clr = clr; v.xlvl = l; v.xfull = f;
        v.xovf = o; v.xbusy = b; v.xstb = s; v.xent = x;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_entry(input logic [39:0] e, output int pc);
        {cmd_op, cmd_addr, cmd_num, cmd_d0, cmd_d1, cmd_d2} = e;
        cmd_push = 1'b1;
        pc = cyc;
        tick();
        cmd_push = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        bit found = 0;
        for (int i = 0; i < 200; i++) begin
            if (sfr_wctrl === 1'b1) begin
                found = 1;
                break;
            end
            tick();
        end
        if (!found) check({name, "_strobe_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_quiet(input string name, output int qc);
        bit found = 0;
        qc = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (seq_busy === 1'b0 && cmd_level === 3'd0) begin
                found = 1;
                qc = cyc;
                break;
            end
        end
        if (!found) check({name, "_quiet_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic clear_log();
        stb_ent.delete();
        stb_cyc.delete();
    endtask

    logic [39:0] e1, e2, e3, e4, e5, e6;
    logic [39:0] f[5];
    logic [39:0] a[3];
    int pc0, pc1, qc, r;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        e1 = mk(1'b1, 7'h1A, 8'h02, 8'hA5, 8'hAA, 8'h5A);
        e2 = mk(1'b0, 7'h05, 8'h01, 8'h11, 8'h22, 8'h33);
        e3 = mk(1'b1, 7'h7F, 8'h03, 8'h44, 8'h55, 8'h66);
        e4 = mk(1'b0, 7'h40, 8'h00, 8'hFF, 8'h00, 8'hFF);
        e5 = mk(1'b1, 7'h2B, 8'h02, 8'hC3, 8'h3C, 8'h96);
        e6 = mk(1'b0, 7'h11, 8'h01, 8'hDE, 8'hAD, 8'hBE);

        //              push ent  en clr  lvl  full ovf busy stb exp_ent
        tbl[0]  = mkv(0, '0, 0, 0, 3'd0, 0, 0, 0, 0, '0);
        tbl[1]  = mkv(1, e1, 1, 0, 3'd1, 0, 0, 0, 0, '0);
        tbl[2]  = mkv(0, '0, 1, 0, 3'd1, 0, 0, 1, 0, '0);
        tbl[3]  = mkv(0, '0, 1, 0, 3'd0, 0, 0, 1, 1, e1);
        tbl[4]  = mkv(0, '0, 1, 0, 3'd0, 0, 0, 0, 0, e1);
        tbl[5]  = mkv(1, e2, 0, 0, 3'd1, 0, 0, 0, 0, e1);
        tbl[6]  = mkv(1, e3, 0, 0, 3'd2, 0, 0, 0, 0, e1);
        tbl[7]  = mkv(1, e4, 0, 0, 3'd3, 0, 0, 0, 0, e1);
        tbl[8]  = mkv(1, e5, 0, 0, 3'd4, 1, 0, 0, 0, e1);
        tbl[9]  = mkv(1, e6, 0, 0, 3'd4, 1, 1, 0, 0, e1);
        tbl[10] = mkv(1, e6, 0, 1, 3'd4, 1, 1, 0, 0, e1);
        tbl[11] = mkv(0, '0, 0, 1, 3'd4, 1, 0, 0, 0, e1);

        rst = 1'b0;
        cmd_push = 0; cmd_op = 0; cmd_addr = '0; cmd_num = '0;
        cmd_d0 = '0; cmd_d1 = '0; cmd_d2 = '0;
        seq_en = 0; flush = 0; gap_cfg = '0; mst_busy = 0; ovf_clr = 0;
        repeat (2) tick();
        check("reset_ent",   oent,      64'd0);
        check("reset_level", cmd_level, 64'd0);
        check("reset_flags", {sfr_wctrl, cmd_full, seq_busy, ovf}, 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            {cmd_op, cmd_addr, cmd_num, cmd_d0, cmd_d1, cmd_d2} = tbl[i].ent;
            cmd_push = tbl[i].push;
            seq_en   = tbl[i].en;
            ovf_clr  = tbl[i].clr;
            tick();
            check($sformatf("vec%0d_level", i), cmd_level, tbl[i].xlvl);
            check($sformatf("vec%0d_full",  i), cmd_full,  tbl[i].xfull);
            check($sformatf("vec%0d_ovf",   i), ovf,       tbl[i].xovf);
            check($sformatf("vec%0d_busy",  i), seq_busy,  tbl[i].xbusy);
            check($sformatf("vec%0d_wctrl", i), sfr_wctrl, tbl[i].xstb);
            check($sformatf("vec%0d_ent",   i), oent,      tbl[i].xent);
        end
        cmd_push = 0; ovf_clr = 0;

        // Full FIFO drains as exactly DEPTH launches in push order.
        clear_log();
        gap_cfg = 16'd3;
        seq_en = 1;
        wait_quiet("drain", qc);
        check("drain_count", stb_ent.size(), 64'd4);
        if (stb_ent.size() == 4) begin
            check("drain_e0", stb_ent[0], e2);
            check("drain_e1", stb_ent[1], e3);
            check("drain_e2", stb_ent[2], e4);
            check("drain_e3", stb_ent[3], e5);
        end

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 5; i++) f[i] = mk(i[0], 7'(8'h30 + i), 8'(i), 8'(8'h80 + i), 8'(8'h90 + i), 8'(8'hA0 + i));
        seq_en = 0; gap_cfg = '0;
        for (int i = 0; i < 4; i++) push_entry(f[i], pc0);
        check("pp_full_before", cmd_full, 64'd1);
        clear_log();
        seq_en = 1;
        tick();
        push_entry(f[4], pc0);
        check("pp_level", cmd_level, 64'd4);
        check("pp_full",  cmd_full,  64'd1);
        check("pp_ovf",   ovf,       64'd0);
        wait_quiet("pp", qc);
        check("pp_count", stb_ent.size(), 64'd5);
        if (stb_ent.size() == 5) check("pp_last", stb_ent[4], f[4]);

        // Three launches with gap 10: strobes 12 cycles apart.
        for (int i = 0; i < 3; i++) a[i] = mk(1'b1, 7'(8'h50 + i), 8'h01, 8'(8'h10 * (i + 1)), 8'h0F, 8'(8'hF0 - i));
        clear_log();
        gap_cfg = 16'd10;
        push_entry(a[0], pc0);
        push_entry(a[1], pc1);
        push_entry(a[2], pc1);
        wait_quiet("gap10", qc);
        check("gap10_count", stb_ent.size(), 64'd3);
        if (stb_ent.size() == 3) begin
            check("gap10_lat",  stb_cyc[0], pc0 + 3);
            check("gap10_sp1",  stb_cyc[1], pc0 + 15);
            check("gap10_sp2",  stb_cyc[2], pc0 + 27);
            check("gap10_ord0", stb_ent[0], a[0]);
            check("gap10_ord1", stb_ent[1], a[1]);
            check("gap10_ord2", stb_ent[2], a[2]);
            check("gap10_idle", qc, pc0 + 38);
        end

        // mst_busy held 50 cycles from the first strobe stalls the next launch.
        clear_log();
        gap_cfg = 16'd5;
        push_entry(e3, pc0);
        push_entry(e4, pc1);
        wait_strobe("busy");
        mst_busy = 1;
        repeat (50) tick();
        check("busy_hold_count", stb_ent.size(), 64'd1);
        mst_busy = 0;
        r = cyc;
        wait_quiet("busy", qc);
        check("busy_count", stb_ent.size(), 64'd2);
        if (stb_ent.size() == 2) begin
            check("busy_release", stb_cyc[1], r + 2);
            check("busy_ent",     stb_ent[1], e4);
        end

        // Flush during the first gap: one strobe, outputs keep the first entry.
        clear_log();
        gap_cfg = 16'd8;
        push_entry(e5, pc0);
        push_entry(e6, pc1);
        push_entry(e2, pc1);
        wait_strobe("flush");
        tick();
        tick();
        flush = 1;
        tick();
        flush = 0;
        check("flush_level", cmd_level, 64'd0);
        check("flush_busy",  seq_busy,  64'd1);
        wait_quiet("flush", qc);
        check("flush_count", stb_ent.size(), 64'd1);
        check("flush_hold",  oent, e5);

        // Flush and push in the same cycle: FIFO empty, no overflow.
        seq_en = 0;
        for (int i = 0; i < 4; i++) push_entry(f[i], pc0);
        flush = 1;
        push_entry(e1, pc0);
        flush = 0;
        check("flushpush_level", cmd_level, 64'd0);
        check("flushpush_ovf",   ovf,       64'd0);
        seq_en = 1;

        // Asynchronous reset in GAP with two entries still queued.
        clear_log();
        gap_cfg = 16'd20;
        push_entry(e3, pc0);
        push_entry(e4, pc1);
        push_entry(e5, pc1);
        wait_strobe("rst");
        repeat (3) tick();
        check("rst_pre_level", cmd_level, 64'd2);
        #2 rst = 1'b0;
        #1;
        check("rst_ent",   oent,      64'd0);
        check("rst_level", cmd_level, 64'd0);
        check("rst_flags", {sfr_wctrl, cmd_full, seq_busy, ovf}, 64'd0);
        clear_log();
        repeat (3) tick();
        rst = 1'b1;
        repeat (20) tick();
        check("rst_no_strobe", stb_ent.size(), 64'd0);
        push_entry(e6, pc0);
        wait_quiet("rst_after", qc);
        check("rst_new_count", stb_ent.size(), 64'd1);
        if (stb_ent.size() == 1) check("rst_new_ent", stb_ent[0], e6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
